// File: rtl/decode_stage_if.sv
// Fetch->decode->execute handshake bundle for the decode stage.
interface decode_stage_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_inst;
  logic [31:0] in_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [31:0] out_imm;
  logic [4:0]  out_rs1;
  logic [4:0]  out_rs2;
  logic [4:0]  out_rd;
  logic [21:0] out_ctrl;
  logic        out_exc;
  logic [3:0]  out_cause;

  // stage side
  modport master (
    input  in_valid, in_inst, in_pc, out_ready,
    output in_ready, out_valid, out_pc, out_imm, out_rs1, out_rs2, out_rd,
           out_ctrl, out_exc, out_cause
  );

  // fetch/execute side
  modport slave (
    output in_valid, in_inst, in_pc, out_ready,
    input  in_ready, out_valid, out_pc, out_imm, out_rs1, out_rs2, out_rd,
           out_ctrl, out_exc, out_cause
  );
endinterface

// File: rtl/decode_stage.sv
// Registered RV32I/E decode stage: main output register plus one-entry raw
// skid, flush, trap detection and a saturating stall counter.
module decode_stage #(
  parameter bit RV32E    = 1'b0,
  parameter bit EN_ZICSR = 1'b1,
  parameter bit JAL_TRAP = 1'b1,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             resetb,
  input  logic             flush,
  decode_stage_if.master   bus,
  output logic [CNT_W-1:0] stall_cnt
);

  typedef struct packed {
    logic       lui;
    logic       auipc;
    logic       mret;
    logic [1:0] csr_op;
    logic       csr_imm;
    logic       csr;
    logic [1:0] mem_size;
    logic       mem_sext;
    logic       store;
    logic       load;
    logic       branch;
    logic       jalr;
    logic       jal;
    logic       regwrite;
    logic       op2_imm;
    logic       alu_signed;
    logic [3:0] alu_op;
  } ctrl_t;

  localparam logic [3:0] ALU_ADD = 4'd0, ALU_SUB = 4'd1, ALU_SLT = 4'd3, ALU_SRA = 4'd6;

  function automatic logic [3:0] alu_of(input logic [2:0] f3);
    case (f3)
      3'b000:  alu_of = 4'd0;
      3'b001:  alu_of = 4'd2;
      3'b010:  alu_of = 4'd3;
      3'b011:  alu_of = 4'd3;
      3'b100:  alu_of = 4'd4;
      3'b101:  alu_of = 4'd5;
      3'b110:  alu_of = 4'd7;
      default: alu_of = 4'd8;
    endcase
  endfunction

  logic        skid_full;
  logic [31:0] skid_inst, skid_pc;
  logic        accept, handoff, main_load;

  assign accept    = bus.in_valid & bus.in_ready;
  assign handoff   = bus.out_valid & bus.out_ready;
  assign main_load = !bus.out_valid | handoff;

  // The skid holds the raw instruction; whichever entry feeds main is decoded.
  logic [31:0] inst, pc;
  assign inst = skid_full ? skid_inst : bus.in_inst;
  assign pc   = skid_full ? skid_pc   : bus.in_pc;

  logic [6:0] opc, f7;
  logic [2:0] f3;
  assign opc = inst[6:0];
  assign f3  = inst[14:12];
  assign f7  = inst[31:25];

  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  assign imm_i = {{20{inst[31]}}, inst[31:20]};
  assign imm_s = {{20{inst[31]}}, inst[31:25], inst[11:7]};
  assign imm_b = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
  assign imm_u = {inst[31:12], 12'b0};
  assign imm_j = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};

  ctrl_t       c;
  logic [31:0] imm;
  logic [4:0]  rs1;
  logic        illegal, ecall, ebreak, tgt_chk, misal, exc;
  logic        use_rs1, use_rs2, use_rd;
  logic [3:0]  cause;

  // Instruction decode and trap classification of the selected entry.
  always_comb begin
    c = '0;
    c.alu_signed = 1'b1;
    imm = '0;
    rs1 = inst[19:15];
    illegal = 1'b0; ecall = 1'b0; ebreak = 1'b0; tgt_chk = 1'b0;
    use_rs1 = 1'b0; use_rs2 = 1'b0; use_rd = 1'b0;
    case (opc)
      7'b0110111: begin c.lui = 1'b1; c.regwrite = 1'b1; c.op2_imm = 1'b1; imm = imm_u;
                        rs1 = 5'd0; use_rd = 1'b1; end
      7'b0010111: begin c.auipc = 1'b1; c.regwrite = 1'b1; c.op2_imm = 1'b1; imm = imm_u;
                        use_rd = 1'b1; end
      7'b1101111: begin c.jal = 1'b1; c.regwrite = 1'b1; imm = imm_j; use_rd = 1'b1;
                        tgt_chk = 1'b1; end
      7'b1100111: begin c.jalr = 1'b1; c.regwrite = 1'b1; c.op2_imm = 1'b1; imm = imm_i;
                        use_rs1 = 1'b1; use_rd = 1'b1; end
      7'b1100011: begin
        c.branch = 1'b1; imm = imm_b; use_rs1 = 1'b1; use_rs2 = 1'b1; tgt_chk = 1'b1;
        c.alu_op = f3[2] ? ALU_SLT : ALU_SUB;
        c.alu_signed = !(f3[2] & f3[1]);
        illegal = (f3 == 3'b010) || (f3 == 3'b011);
      end
      7'b0000011: begin
        c.load = 1'b1; c.regwrite = 1'b1; c.op2_imm = 1'b1; imm = imm_i;
        c.mem_sext = !f3[2]; c.mem_size = f3[1:0]; use_rs1 = 1'b1; use_rd = 1'b1;
        illegal = (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
      end
      7'b0100011: begin
        c.store = 1'b1; c.op2_imm = 1'b1; imm = imm_s; c.mem_size = f3[1:0];
        use_rs1 = 1'b1; use_rs2 = 1'b1;
        illegal = f3[2] || (f3[1:0] == 2'b11);
      end
      7'b0010011: begin
        c.regwrite = 1'b1; c.op2_imm = 1'b1; use_rs1 = 1'b1; use_rd = 1'b1;
        c.alu_op = alu_of(f3); c.alu_signed = (f3 != 3'b011);
        if (f3 == 3'b001 || f3 == 3'b101) begin
          imm = {27'b0, inst[24:20]};
          if (f3 == 3'b101 && f7 == 7'b0100000) c.alu_op = ALU_SRA;
          illegal = (f3 == 3'b001) ? (f7 != 7'b0) : (f7 != 7'b0 && f7 != 7'b0100000);
        end else begin
          imm = imm_i;
        end
      end
      7'b0110011: begin
        c.regwrite = 1'b1; use_rs1 = 1'b1; use_rs2 = 1'b1; use_rd = 1'b1;
        c.alu_op = alu_of(f3); c.alu_signed = (f3 != 3'b011);
        if (f7 == 7'b0100000 && f3 == 3'b000) c.alu_op = ALU_SUB;
        if (f7 == 7'b0100000 && f3 == 3'b101) c.alu_op = ALU_SRA;
        illegal = !(f7 == 7'b0 || (f7 == 7'b0100000 && (f3 == 3'b000 || f3 == 3'b101)));
      end
      7'b0001111: ; // FENCE: no architectural effect in this pipeline
      7'b1110011: begin
        if (f3 == 3'b000) begin
          if (inst == 32'h0000_0073)      ecall  = 1'b1;
          else if (inst == 32'h0010_0073) ebreak = 1'b1;
          else if (inst == 32'h3020_0073) c.mret = 1'b1;
          else                            illegal = 1'b1;
        end else begin
          c.csr = 1'b1; c.csr_imm = f3[2]; c.csr_op = f3[1:0]; c.regwrite = 1'b1;
          imm = {20'b0, inst[31:20]};
          use_rs1 = !f3[2]; use_rd = 1'b1;
          illegal = !EN_ZICSR || (f3 == 3'b100);
        end
      end
      default: illegal = 1'b1;
    endcase
    if (inst[1:0] != 2'b11) illegal = 1'b1;
    if (RV32E && ((use_rs1 && inst[19]) || (use_rs2 && inst[24]) || (use_rd && inst[11])))
      illegal = 1'b1;
    // B/J immediates have bit0 clear, so (pc+imm)[1] needs no carry term.
    misal = JAL_TRAP && tgt_chk && (pc[1] ^ imm[1]);
    exc   = illegal | ecall | ebreak | misal;
    cause = illegal ? 4'd2 : ecall ? 4'd11 : ebreak ? 4'd3 : 4'd0;
    if (exc) begin
      c.regwrite = 1'b0; c.store = 1'b0; c.csr = 1'b0; c.mret = 1'b0;
    end
  end

  // Main/skid occupancy, output register load and registered in_ready.
  always_ff @(posedge clk) begin
    if (!resetb) begin
      bus.out_valid <= 1'b0; bus.in_ready <= 1'b1; skid_full <= 1'b0;
      skid_inst <= '0; skid_pc <= '0;
      bus.out_pc <= '0; bus.out_imm <= '0; bus.out_rs1 <= '0; bus.out_rs2 <= '0;
      bus.out_rd <= '0; bus.out_ctrl <= '0; bus.out_exc <= 1'b0; bus.out_cause <= '0;
    end else if (flush) begin
      bus.out_valid <= 1'b0; bus.in_ready <= 1'b1; skid_full <= 1'b0;
    end else if (main_load) begin
      // skid_full implies in_ready=0, so skid drain and accept never coincide
      bus.out_valid <= skid_full | accept;
      if (skid_full | accept) begin
        bus.out_pc <= pc; bus.out_imm <= imm; bus.out_rs1 <= rs1;
        bus.out_rs2 <= inst[24:20]; bus.out_rd <= inst[11:7]; bus.out_ctrl <= c;
        bus.out_exc <= exc; bus.out_cause <= cause;
      end
      skid_full <= 1'b0; bus.in_ready <= 1'b1;
    end else if (accept) begin
      skid_inst <= bus.in_inst; skid_pc <= bus.in_pc;
      skid_full <= 1'b1; bus.in_ready <= 1'b0;
    end
  end

  // Saturating count of cycles the bundle waits on execute.
  always_ff @(posedge clk) begin
    if (!resetb)
      stall_cnt <= '0;
    else if (bus.out_valid && !bus.out_ready && stall_cnt != {CNT_W{1'b1}})
      stall_cnt <= stall_cnt + 1'b1;
  end

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage: default build plus an RV32E / no-target-trap
// build with a 2-bit stall counter, both fed the same stimulus.
module tb_decode_stage;
  logic        clk = 1'b0;
  logic        resetb, flush, in_valid, out_ready;
  logic [31:0] in_inst, in_pc;
  logic [15:0] stall0;
  logic [1:0]  stall1;
  int          checks = 0, failures = 0;

  always #5 clk = ~clk;

  decode_stage_if if0 ();
  decode_stage_if if1 ();

  assign if0.in_valid = in_valid;  assign if1.in_valid = in_valid;
  assign if0.in_inst  = in_inst;   assign if1.in_inst  = in_inst;
  assign if0.in_pc    = in_pc;     assign if1.in_pc    = in_pc;
  assign if0.out_ready = out_ready; assign if1.out_ready = out_ready;

  decode_stage dut0 (.clk(clk), .resetb(resetb), .flush(flush), .bus(if0), .stall_cnt(stall0));
  decode_stage #(.RV32E(1'b1), .JAL_TRAP(1'b0), .CNT_W(2))
    dut1 (.clk(clk), .resetb(resetb), .flush(flush), .bus(if1), .stall_cnt(stall1));

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic apply(input logic [31:0] inst, input logic [31:0] pc);
    in_valid = 1'b1; in_inst = inst; in_pc = pc;
    step();
    in_valid = 1'b0;
  endtask

  initial begin
    resetb = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_inst = '0; in_pc = '0;
    step(); step();
    chk("rst_valid", 32'(if0.out_valid), 32'd0);
    chk("rst_ready", 32'(if0.in_ready), 32'd1);
    chk("rst_ctrl",  32'(if0.out_ctrl), 32'd0);
    chk("rst_imm",   if0.out_imm, 32'd0);
    chk("rst_stall", 32'(stall0), 32'd0);

    // ADDI x1,x0,-1
    resetb = 1'b1; out_ready = 1'b1;
    apply(32'hFFF00093, 32'h0);
    chk("addi_valid", 32'(if0.out_valid), 32'd1);
    chk("addi_imm",   if0.out_imm, 32'hFFFFFFFF);
    chk("addi_alu",   32'(if0.out_ctrl[3:0]), 32'd0);
    chk("addi_op2i",  32'(if0.out_ctrl[5]), 32'd1);
    chk("addi_rw",    32'(if0.out_ctrl[6]), 32'd1);
    chk("addi_exc",   32'(if0.out_exc), 32'd0);
    chk("addi_rd",    32'(if0.out_rd), 32'd1);
    step();
    chk("drain_valid", 32'(if0.out_valid), 32'd0);

    // Stream A..D into a stalled execute: only A (main) and B (skid) get in.
    out_ready = 1'b0;
    in_valid = 1'b1; in_inst = 32'h00100093; in_pc = 32'h10; step();
    in_inst = 32'h00200113; in_pc = 32'h14; step();
    in_inst = 32'h00300193; in_pc = 32'h18; step();
    chk("str_ready0", 32'(if0.in_ready), 32'd0);
    chk("str_stall2", 32'(stall0), 32'd2);
    chk("str_holdA",  if0.out_imm, 32'd1);
    step(); step();
    chk("str_stall4", 32'(stall0), 32'd4);
    chk("str_sat",    32'(stall1), 32'd3);
    chk("str_stillA", if0.out_pc, 32'h10);
    out_ready = 1'b1; step();
    chk("str_B_imm", if0.out_imm, 32'd2);
    chk("str_B_pc",  if0.out_pc, 32'h14);
    chk("str_ready1", 32'(if0.in_ready), 32'd1);
    chk("str_stallhold", 32'(stall0), 32'd4);
    step();
    chk("str_C_imm", if0.out_imm, 32'd3);
    in_inst = 32'h00400213; in_pc = 32'h1C; step();
    chk("str_D_imm", if0.out_imm, 32'd4);
    chk("str_D_rd",  32'(if0.out_rd), 32'd4);
    in_valid = 1'b0; step();
    chk("str_empty", 32'(if0.out_valid), 32'd0);

    // JAL x1,+6 at pc 0: misaligned target on dut0, not trapped on dut1
    apply(32'h006000EF, 32'h0);
    chk("jal_imm",   if0.out_imm, 32'd6);
    chk("jal_exc",   32'(if0.out_exc), 32'd1);
    chk("jal_cause", 32'(if0.out_cause), 32'd0);
    chk("jal_rw",    32'(if0.out_ctrl[6]), 32'd0);
    chk("jal_bit",   32'(if0.out_ctrl[7]), 32'd1);
    chk("jal_nt_exc", 32'(if1.out_exc), 32'd0);
    chk("jal_nt_rw",  32'(if1.out_ctrl[6]), 32'd1);

    // ADD x17,x1,x2
    apply(32'h002088B3, 32'h4);
    chk("add_exc",   32'(if0.out_exc), 32'd0);
    chk("add_rd",    32'(if0.out_rd), 32'd17);
    chk("add_imm",   if0.out_imm, 32'd0);
    chk("add_e_exc", 32'(if1.out_exc), 32'd1);
    chk("add_e_cause", 32'(if1.out_cause), 32'd2);

    apply(32'h00000073, 32'h8);
    chk("ecall_exc",   32'(if0.out_exc), 32'd1);
    chk("ecall_cause", 32'(if0.out_cause), 32'd11);
    apply(32'h00100073, 32'hC);
    chk("ebreak_cause", 32'(if0.out_cause), 32'd3);
    apply(32'h00000000, 32'h10);
    chk("zero_exc",   32'(if0.out_exc), 32'd1);
    chk("zero_cause", 32'(if0.out_cause), 32'd2);

    // BEQ x0,x0,+8: aligned at pc 0, misaligned at pc 2
    apply(32'h00000463, 32'h0);
    chk("beq_imm",    if0.out_imm, 32'd8);
    chk("beq_branch", 32'(if0.out_ctrl[9]), 32'd1);
    chk("beq_exc",    32'(if0.out_exc), 32'd0);
    apply(32'h00000463, 32'h2);
    chk("beq2_exc",   32'(if0.out_exc), 32'd1);
    chk("beq2_cause", 32'(if0.out_cause), 32'd0);

    // LUI x5,0x12345: rs1 field is not a register
    apply(32'h123452B7, 32'h0);
    chk("lui_imm", if0.out_imm, 32'h12345000);
    chk("lui_rs1", 32'(if0.out_rs1), 32'd0);
    chk("lui_bit", 32'(if0.out_ctrl[21]), 32'd1);

    // SRAI x1,x1,3
    apply(32'h4030D093, 32'h0);
    chk("srai_imm", if0.out_imm, 32'd3);
    chk("srai_alu", 32'(if0.out_ctrl[3:0]), 32'd6);
    chk("srai_exc", 32'(if0.out_exc), 32'd0);

    // LW x1,-4(x2)
    apply(32'hFFC12083, 32'h0);
    chk("lw_imm",  if0.out_imm, 32'hFFFFFFFC);
    chk("lw_load", 32'(if0.out_ctrl[10]), 32'd1);
    chk("lw_size", 32'(if0.out_ctrl[14:13]), 32'd2);
    chk("lw_sext", 32'(if0.out_ctrl[12]), 32'd1);
    step();

    // Fill main+skid, then flush with a same-cycle offer
    out_ready = 1'b0;
    in_valid = 1'b1; in_inst = 32'h00100093; step();
    in_inst = 32'h00200113; step();
    chk("fl_full", 32'(if0.in_ready), 32'd0);
    flush = 1'b1; in_inst = 32'h00300193; step();
    chk("fl_valid", 32'(if0.out_valid), 32'd0);
    chk("fl_ready", 32'(if0.in_ready), 32'd1);
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1; step();
    chk("fl_noleak", 32'(if0.out_valid), 32'd0);

    // Reset mid-stream
    out_ready = 1'b0; in_valid = 1'b1; in_inst = 32'hFFF00093;
    step(); step(); step();
    resetb = 1'b0; step();
    chk("mr_valid", 32'(if0.out_valid), 32'd0);
    chk("mr_ready", 32'(if0.in_ready), 32'd1);
    chk("mr_imm",   if0.out_imm, 32'd0);
    chk("mr_ctrl",  32'(if0.out_ctrl), 32'd0);
    chk("mr_stall", 32'(stall0), 32'd0);
    resetb = 1'b1; in_valid = 1'b0; step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
